// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the MEM/WB write-back stage: load-type codes,
// the $zero register number and the registered control bundle.
package wb_pkg;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control half of the MEM/WB register; the datapath words are kept
  // separately because their width is a module parameter.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic [2:0] load_type;
    logic [4:0] write_reg;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_BUBBLE = '0;

endpackage : wb_pkg

// File: rtl/writeback_stage_load_extract.sv
// Big-endian sub-word load extraction with sign/zero extension.
// Purely combinational so the memory stage can reuse it.
module load_extract
  import wb_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] i_word,
  input  logic [1:0]   i_offset,
  input  logic [2:0]   i_type,
  output logic [n-1:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

    w_byte = i_word[31:24];
    case (i_offset)
      2'd0: w_byte = i_word[31:24];
      2'd1: w_byte = i_word[23:16];
      2'd2: w_byte = i_word[15:8];
      2'd3: w_byte = i_word[7:0];
      default: w_byte = i_word[31:24];
    endcase
  end

  // Unused codes 101..111 fall through to the full-word default.
  always_comb begin
    o_data = i_word;
    case (i_type)
      LT_LH:   o_data = {{(n-16){w_half[15]}}, w_half};
      LT_LHU:  o_data = {{(n-16){1'b0}}, w_half};
      LT_LB:   o_data = {{(n-8){w_byte[7]}}, w_byte};
      LT_LBU:  o_data = {{(n-8){1'b0}}, w_byte};
      default: o_data = i_word;
    endcase
  end

endmodule : load_extract

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back data selection, register-file
// write port drive and a retired-instruction counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int n     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic             mem_valid_in,
  input  logic             mem_reg_write_in,
  input  logic             mem_mem_to_reg_in,
  input  logic [2:0]       mem_load_type_in,
  input  logic [4:0]       mem_write_reg_in,
  input  logic [n-1:0]     mem_alu_result_in,
  input  logic [n-1:0]     mem_read_data_in,
  output logic             reg_write_bit_out,
  output logic [4:0]       write_reg_out,
  output logic [n-1:0]     write_data_out,
  output logic             wb_valid_out,
  output logic [CNT_W-1:0] retired_count_out
);

  wb_ctrl_t         r_ctrl;
  logic [n-1:0]     r_alu_result;
  logic [n-1:0]     r_read_data;
  logic [CNT_W-1:0] r_retired_count;

  logic [n-1:0]     w_load_data;
  logic             w_leaving;

  // The WB instruction leaves the stage whenever the register is not held.
  assign w_leaving = r_ctrl.valid & (flush_in | ~stall_in);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl       <= WB_CTRL_BUBBLE;
      r_alu_result <= '0;
      r_read_data  <= '0;
    end else if (flush_in) begin
      r_ctrl       <= WB_CTRL_BUBBLE;
      r_alu_result <= '0;
      r_read_data  <= '0;
    end else if (!stall_in) begin
      r_ctrl.valid      <= mem_valid_in;
      r_ctrl.reg_write  <= mem_reg_write_in;
      r_ctrl.mem_to_reg <= mem_mem_to_reg_in;
      r_ctrl.load_type  <= mem_load_type_in;
      r_ctrl.write_reg  <= mem_write_reg_in;
      r_alu_result      <= mem_alu_result_in;
      r_read_data       <= mem_read_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired_count <= '0;
    end else if (w_leaving) begin
      r_retired_count <= r_retired_count + CNT_W'(1);
    end
  end

  load_extract #(
    .n (n)
  ) u_load_extract (
    .i_word   (r_read_data),
    .i_offset (r_alu_result[1:0]),
    .i_type   (r_ctrl.load_type),
    .o_data   (w_load_data)
  );

  // Outputs depend on registered state only, so they hold for the whole
  // cycle and repeat unchanged while stalled.
  always_comb begin
    reg_write_bit_out = 1'b0;
    write_reg_out     = REG_ZERO;
    write_data_out    = '0;
    if (r_ctrl.valid) begin
      reg_write_bit_out = r_ctrl.reg_write & (r_ctrl.write_reg != REG_ZERO);
      write_reg_out     = r_ctrl.write_reg;
      write_data_out    = r_ctrl.mem_to_reg ? w_load_data : r_alu_result;
    end
  end

  assign wb_valid_out      = r_ctrl.valid;
  assign retired_count_out = r_retired_count;

endmodule : writeback_stage

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back selection logic for the 32-bit MIPS pipeline.
- Captures the memory-stage result each cycle.
- Picks ALU result or extracted load data, and drives the write side of the register file: write enable, destination and data.
- Counts retired instructions and supports pipeline stall and flush from the hazard unit.

Parameters:
- n, 32, datapath width; rdata/write_data width of the register file.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- stall_in  input  1  hold the MEM/WB register contents
- flush_in  input  1  load a bubble into MEM/WB; has priority over stall_in
- mem_valid_in  input  1  memory-stage slot holds a real instruction
- mem_reg_write_in  input  1  instruction writes a register
- mem_mem_to_reg_in  input  1  1 = load data, 0 = ALU result
- mem_load_type_in  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
- mem_write_reg_in  input  5  destination register number
- mem_alu_result_in  input  n  ALU result; bits [1:0] are the load byte offset
- mem_read_data_in  input  n  raw aligned word from data memory
- reg_write_bit_out  output  1  register-file write enable
- write_reg_out  output  5  register-file write address
- write_data_out  output  n  register-file write data
- wb_valid_out  output  1  WB slot holds a real instruction
- retired_count_out  output  CNT_W  instructions retired since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - all MEM/WB fields and the counter go to 0.
  - Outputs: reg_write_bit_out=0, write_reg_out=0, write_data_out=0, wb_valid_out=0, retired_count_out=0.
- Register update at each posedge:
  - flush_in=1: valid<=0; other fields don't-care but are cleared to 0.
  - else stall_in=0: capture all mem_* inputs.
  - else (stall): hold all fields.
- Latency: one cycle from mem_* inputs to write-back outputs.
- Outputs are combinational from registered state only; no input-to-output paths. They are stable for a full cycle, so the register file samples them at the next posedge.
- reg_write_bit_out = valid & reg_write & (write_reg != 0). Writes to $zero are always suppressed.
- write_reg_out = registered destination when valid, else 0.
- write_data_out:
  - mem_to_reg=0: ALU result.
  - mem_to_reg=1: extracted load data (below).
  - valid=0: 0.
- Load extraction (big-endian; offset = registered alu_result[1:0]):
  - LW: full word; offset ignored.
  - LH/LHU: offset[1]=0 selects bits [31:16], 1 selects [15:0]. Sign- or zero-extend to n. offset[0] ignored; misaligned halfwords are not trapped.
  - LB/LBU: offset 0..3 selects bits [31:24], [23:16], [15:8], [7:0]. Sign- or zero-extend.
  - Codes 101..111 behave as LW.
- Stall with valid instruction: write-back outputs repeat every stalled cycle. Repeated writes are idempotent and intended.
- Retired counter increments by 1 at a posedge when valid=1 and (flush_in=1 or stall_in=0), i.e. the WB instruction leaves the stage.
  - Counts every valid instruction, including ones with reg_write=0 or a $zero destination.
  - Wraps from 2^CNT_W-1 to 0.
- Simultaneous flush and stall: flush wins. The current WB instruction retires and a bubble enters.
- Reset asserted mid-operation: state clears immediately and the pending write is lost. Deassertion is synchronised externally.

Decomposition:
- Shared package wb_pkg: load-type constants LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU; REG_ZERO=5'd0.
- One combinational sub-module load_extract (inputs: word, offset, type; output: n-bit data), reusable by the memory stage.

Test Plan:
1. Reset held, then released with an ALU instruction (reg 5, result 0x0000_1234, reg_write=1) → next cycle: reg_write_bit_out=1, write_reg_out=5, write_data_out=0x0000_1234, retired_count_out=1 one edge later.
2. Load word 0x80FF_7F01, sweeping offsets and types:
   - LB offset 0 → 0xFFFF_FF80
   - LBU offset 0 → 0x0000_0080
   - LB offset 2 → 0x0000_007F
   - LH offset 2 → 0x0000_7F01
   - LHU offset 0 → 0x0000_80FF
   - LW → 0x80FF_7F01
3. Write to reg 0 with reg_write=1, data 0xDEAD_BEEF → reg_write_bit_out=0; counter still increments.
4. stall_in=1 for 3 cycles with a valid instruction in WB → outputs constant for 3 cycles, counter unchanged; after release, counter +1 exactly once.
5. flush_in=1 and stall_in=1 together with a valid incoming instruction → next cycle wb_valid_out=0, reg_write_bit_out=0, write_data_out=0; the previous WB instruction is counted.
6. Preload the counter near wrap (CNT_W=4 build), then retire 2 instructions from 14 → count reads 15, then 0. Assert rst mid-stream → all outputs 0 without waiting for a clock edge.
